// File: rtl/dm_cmd_pkg.sv
// Shared constants, state encoding and helpers for the DataMover command queue.
package dm_cmd_pkg;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  localparam int CNT_WIDTH = 16;

  typedef enum logic {
    CQ_EMPTY = 1'b0,
    CQ_HOLD  = 1'b1
  } cq_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    return (&value) ? value : value + CNT_WIDTH'(1);
  endfunction

  // A status word is bad when OKAY is missing or any error bit is set; TAG is ignored.
  function automatic logic sts_bad(input logic [7:0] sts);
    return ~sts[STS_OKAY] | sts[STS_SLVERR] | sts[STS_DECERR] | sts[STS_INTERR];
  endfunction

endpackage

// File: rtl/dm_cmd_fifo.sv
// Circular command buffer with extra-bit pointers; exposes head and head+1 words
// so the output stage can reload at one word per cycle.
module dm_cmd_fifo
  import dm_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 79,
  parameter int LOG_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] rdata_next,
  output logic                  full,
  output logic                  empty,
  output logic [LOG_DEPTH:0]    level
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG_DEPTH:0]    wptr;
  logic [LOG_DEPTH:0]    rptr;
  logic [LOG_DEPTH-1:0]  widx;
  logic [LOG_DEPTH-1:0]  ridx;
  logic [LOG_DEPTH-1:0]  ridx_next;

  assign widx      = wptr[LOG_DEPTH-1:0];
  assign ridx      = rptr[LOG_DEPTH-1:0];
  assign ridx_next = ridx + LOG_DEPTH'(1);

  assign level      = wptr - rptr;
  assign full       = (level == (LOG_DEPTH+1)'(DEPTH));
  assign empty      = (wptr == rptr);
  assign rdata      = mem[ridx];
  assign rdata_next = mem[ridx_next];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (LOG_DEPTH+1)'(1);
      if (pop)  rptr <= rptr + (LOG_DEPTH+1)'(1);
    end
  end

  // Storage needs no reset: only slots between rptr and wptr are ever read as valid.
  always_ff @(posedge clk) begin
    if (push) mem[widx] <= wdata;
  end

endmodule

// File: rtl/dm_cmd_queue.sv
// Command queue from sync_manager to the DataMover S2MM command port, with drop
// accounting and optional status tracking (enable with DM_STS_CHECK_EN).
module dm_cmd_queue
  import dm_cmd_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int CMD_WIDTH     = MM_ADDR_WIDTH + 47,
  parameter int LOG_DEPTH     = 2
) (
  input  logic                  SYS_aclk,
  input  logic                  SYS_aresetn,
  input  logic                  S_AXIS_tvalid,
  input  logic [CMD_WIDTH-1:0]  S_AXIS_tdata,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [CMD_WIDTH-1:0]  M_AXIS_tdata,
  input  logic                  S_AXIS_STS_tvalid,
  input  logic [7:0]            S_AXIS_STS_tdata,
  output logic                  S_AXIS_STS_tready,
  input  logic                  CQ_clear,
  output logic [LOG_DEPTH:0]    CQ_level,
  output logic                  CQ_overflow,
  output logic [CNT_WIDTH-1:0]  CQ_drop_count,
  output logic [LOG_DEPTH+1:0]  CQ_outstanding,
  output logic [CNT_WIDTH-1:0]  CQ_error_count
);

  cq_state_e             state;
  cq_state_e             state_nxt;
  logic [CMD_WIDTH-1:0]  head;
  logic [CMD_WIDTH-1:0]  head_nxt;
  logic [CMD_WIDTH-1:0]  fifo_rdata;
  logic [CMD_WIDTH-1:0]  fifo_rdata_next;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LOG_DEPTH:0]    fifo_level;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;
  logic                  sts_ready;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  drop_count;

  assign pop     = (state == CQ_HOLD) & M_AXIS_tready;
  assign push_ok = S_AXIS_tvalid & (~fifo_full | pop);
  assign drop    = S_AXIS_tvalid & fifo_full & ~pop;

  // The head register mirrors the FIFO entry at rptr, so the FIFO level already counts it.
  dm_cmd_fifo #(
    .DATA_WIDTH (CMD_WIDTH),
    .LOG_DEPTH  (LOG_DEPTH)
  ) u_fifo (
    .clk        (SYS_aclk),
    .rst_n      (SYS_aresetn),
    .push       (push_ok),
    .pop        (pop),
    .wdata      (S_AXIS_tdata),
    .rdata      (fifo_rdata),
    .rdata_next (fifo_rdata_next),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      state <= CQ_EMPTY;
      head  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
    end
  end

  // On a pop, the next head is the following FIFO entry, or the incoming pulse when
  // the popped word was the last one stored.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    case (state)
      CQ_EMPTY: begin
        if (!fifo_empty) begin
          state_nxt = CQ_HOLD;
          head_nxt  = fifo_rdata;
        end else if (S_AXIS_tvalid) begin
          state_nxt = CQ_HOLD;
          head_nxt  = S_AXIS_tdata;
        end
      end
      CQ_HOLD: begin
        if (pop) begin
          if (fifo_level > (LOG_DEPTH+1)'(1)) begin
            head_nxt = fifo_rdata_next;
          end else if (S_AXIS_tvalid) begin
            head_nxt = S_AXIS_tdata;
          end else begin
            state_nxt = CQ_EMPTY;
          end
        end
      end
      default: state_nxt = CQ_EMPTY;
    endcase
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      sts_ready <= 1'b0;
    end else begin
      sts_ready <= 1'b1;
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (CQ_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= sat_inc(drop_count);
    end
  end

`ifdef DM_STS_CHECK_EN
  logic                  sts;
  logic                  spurious;
  logic                  sts_err;
  logic [LOG_DEPTH+1:0]  outstanding;
  logic [CNT_WIDTH-1:0]  error_count;

  assign sts      = S_AXIS_STS_tvalid & sts_ready;
  assign spurious = sts & (outstanding == '0) & ~pop;
  assign sts_err  = sts & sts_bad(S_AXIS_STS_tdata);

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      outstanding <= '0;
    end else begin
      case ({pop, sts})
        2'b10:   if (!(&outstanding)) outstanding <= outstanding + (LOG_DEPTH+2)'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - (LOG_DEPTH+2)'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
    if (!SYS_aresetn) begin
      error_count <= '0;
    end else if (CQ_clear) begin
      error_count <= '0;
    end else if (spurious | sts_err) begin
      error_count <= sat_inc(error_count);
    end
  end

  assign CQ_outstanding = outstanding;
  assign CQ_error_count = error_count;
`else
  logic sts_unused;
  assign sts_unused     = &{1'b0, S_AXIS_STS_tvalid, S_AXIS_STS_tdata};
  assign CQ_outstanding = '0;
  assign CQ_error_count = '0;
`endif

  assign M_AXIS_tvalid     = (state == CQ_HOLD);
  assign M_AXIS_tdata      = head;
  assign S_AXIS_STS_tready = sts_ready;
  assign CQ_level          = fifo_level;
  assign CQ_overflow       = overflow;
  assign CQ_drop_count     = drop_count;

endmodule

// File: tb/tb_dm_cmd_queue.sv
// Scoreboard bench for dm_cmd_queue: directed pulses push expected words, a negedge
// monitor pops and compares every accepted DataMover command.
module tb_dm_cmd_queue;

  localparam int MM_ADDR_WIDTH = 32;
  localparam int CMD_WIDTH     = MM_ADDR_WIDTH + 47;
  localparam int LOG_DEPTH     = 2;
  localparam int CW            = 128;
`ifdef DM_STS_CHECK_EN
  localparam bit STS_ON = 1'b1;
`else
  localparam bit STS_ON = 1'b0;
`endif

  logic                  SYS_aclk;
  logic                  SYS_aresetn;
  logic                  S_AXIS_tvalid;
  logic [CMD_WIDTH-1:0]  S_AXIS_tdata;
  logic                  M_AXIS_tvalid;
  logic                  M_AXIS_tready;
  logic [CMD_WIDTH-1:0]  M_AXIS_tdata;
  logic                  S_AXIS_STS_tvalid;
  logic [7:0]            S_AXIS_STS_tdata;
  logic                  S_AXIS_STS_tready;
  logic                  CQ_clear;
  logic [LOG_DEPTH:0]    CQ_level;
  logic                  CQ_overflow;
  logic [15:0]           CQ_drop_count;
  logic [LOG_DEPTH+1:0]  CQ_outstanding;
  logic [15:0]           CQ_error_count;

  logic [CMD_WIDTH-1:0]  exp_q[$];
  logic [CMD_WIDTH-1:0]  mon_exp;
  logic [CMD_WIDTH-1:0]  words [6];
  int                    check_count = 0;
  int                    error_count = 0;

  dm_cmd_queue #(
    .MM_ADDR_WIDTH (MM_ADDR_WIDTH),
    .CMD_WIDTH     (CMD_WIDTH),
    .LOG_DEPTH     (LOG_DEPTH)
  ) dut (
    .SYS_aclk          (SYS_aclk),
    .SYS_aresetn       (SYS_aresetn),
    .S_AXIS_tvalid     (S_AXIS_tvalid),
    .S_AXIS_tdata      (S_AXIS_tdata),
    .M_AXIS_tvalid     (M_AXIS_tvalid),
    .M_AXIS_tready     (M_AXIS_tready),
    .M_AXIS_tdata      (M_AXIS_tdata),
    .S_AXIS_STS_tvalid (S_AXIS_STS_tvalid),
    .S_AXIS_STS_tdata  (S_AXIS_STS_tdata),
    .S_AXIS_STS_tready (S_AXIS_STS_tready),
    .CQ_clear          (CQ_clear),
    .CQ_level          (CQ_level),
    .CQ_overflow       (CQ_overflow),
    .CQ_drop_count     (CQ_drop_count),
    .CQ_outstanding    (CQ_outstanding),
    .CQ_error_count    (CQ_error_count)
  );

  initial SYS_aclk = 1'b0;
  always #5 SYS_aclk = ~SYS_aclk;

  task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                             input logic [CW-1:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One-cycle command pulse; accepted words are queued for the monitor.
  task automatic applyStimulus(input logic [CMD_WIDTH-1:0] data, input bit accept);
    S_AXIS_tvalid = 1'b1;
    S_AXIS_tdata  = data;
    if (accept) exp_q.push_back(data);
    @(posedge SYS_aclk);
    #1;
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic applyStatus(input logic [7:0] sts);
    S_AXIS_STS_tvalid = 1'b1;
    S_AXIS_STS_tdata  = sts;
    @(posedge SYS_aclk);
    #1;
    S_AXIS_STS_tvalid = 1'b0;
  endtask

  always @(negedge SYS_aclk) begin
    if (SYS_aresetn && M_AXIS_tvalid && M_AXIS_tready) begin
      if (exp_q.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL unexpected_word: got %0h expected none", M_AXIS_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("m_axis_tdata", CW'(M_AXIS_tdata), CW'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    words[0] = 79'h1_0000_0040_0400;
    words[1] = 79'h4ABC_1111_2222_3333_4444;
    words[2] = 79'h0012_5555_6666_7777_8888;
    words[3] = 79'h7FFF_9999_AAAA_BBBB_CCCC;
    words[4] = 79'h0000_DEAD_BEEF_0000_0001;
    words[5] = 79'h3333_0F0F_F0F0_1234_5678;

    SYS_aresetn       = 1'b1;
    S_AXIS_tvalid     = 1'b0;
    S_AXIS_tdata      = '0;
    M_AXIS_tready     = 1'b0;
    S_AXIS_STS_tvalid = 1'b0;
    S_AXIS_STS_tdata  = '0;
    CQ_clear          = 1'b0;
    #1 SYS_aresetn = 1'b0;

    repeat (2) @(posedge SYS_aclk);
    #1;
    checkOutput("rst_tvalid", CW'(M_AXIS_tvalid), CW'(0));
    checkOutput("rst_sts_tready", CW'(S_AXIS_STS_tready), CW'(0));
    checkOutput("rst_level", CW'(CQ_level), CW'(0));
    checkOutput("rst_tdata", CW'(M_AXIS_tdata), CW'(0));
    SYS_aresetn = 1'b1;
    @(posedge SYS_aclk);
    #1;
    checkOutput("sts_tready_after_rst", CW'(S_AXIS_STS_tready), CW'(1));
    checkOutput("drop_after_rst", CW'(CQ_drop_count), CW'(0));

    // Single pulse with tready high: valid exactly one cycle later, then drained.
    M_AXIS_tready = 1'b1;
    checkOutput("t1_tvalid_before", CW'(M_AXIS_tvalid), CW'(0));
    applyStimulus(79'h1_0000_0040_0400, 1'b1);
    checkOutput("t1_tvalid", CW'(M_AXIS_tvalid), CW'(1));
    checkOutput("t1_tdata", CW'(M_AXIS_tdata), CW'(79'h1_0000_0040_0400));
    checkOutput("t1_level", CW'(CQ_level), CW'(1));
    @(posedge SYS_aclk);
    #1;
    checkOutput("t1_tvalid_after", CW'(M_AXIS_tvalid), CW'(0));
    checkOutput("t1_level_after", CW'(CQ_level), CW'(0));

    // Six pulses into a stalled queue of depth 4: last two dropped.
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulus(words[i], i < 4);
    checkOutput("t2_level", CW'(CQ_level), CW'(4));
    checkOutput("t2_overflow", CW'(CQ_overflow), CW'(1));
    checkOutput("t2_drop_count", CW'(CQ_drop_count), CW'(2));
    checkOutput("t2_head_stable", CW'(M_AXIS_tdata), CW'(words[0]));

    CQ_clear = 1'b1;
    @(posedge SYS_aclk);
    #1;
    CQ_clear = 1'b0;
    checkOutput("clr_overflow", CW'(CQ_overflow), CW'(0));
    checkOutput("clr_drop_count", CW'(CQ_drop_count), CW'(0));
    checkOutput("clr_level", CW'(CQ_level), CW'(4));

    // Full queue with coincident push and pop: accepted, level stays at depth.
    M_AXIS_tready = 1'b1;
    applyStimulus(79'h5A5A_0000_1111_2222_0005, 1'b1);
    checkOutput("t3_level", CW'(CQ_level), CW'(4));
    checkOutput("t3_drop_count", CW'(CQ_drop_count), CW'(0));
    checkOutput("t3_overflow", CW'(CQ_overflow), CW'(0));
    repeat (4) @(posedge SYS_aclk);
    #1;
    checkOutput("t3_level_drained", CW'(CQ_level), CW'(0));
    checkOutput("t3_tvalid_drained", CW'(M_AXIS_tvalid), CW'(0));

    // Asynchronous reset while holding three queued commands.
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(words[5-i], 1'b0);
    checkOutput("t4_level_before", CW'(CQ_level), CW'(3));
    checkOutput("t4_tvalid_before", CW'(M_AXIS_tvalid), CW'(1));
    SYS_aresetn = 1'b0;
    #1;
    checkOutput("t4_tvalid_async", CW'(M_AXIS_tvalid), CW'(0));
    checkOutput("t4_level_async", CW'(CQ_level), CW'(0));
    checkOutput("t4_tdata_async", CW'(M_AXIS_tdata), CW'(0));
    checkOutput("t4_outstanding_async", CW'(CQ_outstanding), CW'(0));
    checkOutput("t4_errors_async", CW'(CQ_error_count), CW'(0));
    checkOutput("t4_sts_tready_async", CW'(S_AXIS_STS_tready), CW'(0));
    @(posedge SYS_aclk);
    #1;
    SYS_aresetn = 1'b1;
    @(posedge SYS_aclk);
    #1;
    M_AXIS_tready = 1'b1;
    applyStimulus(79'h0C0C_0000_0000_0000_00C0, 1'b1);
    checkOutput("t4_tvalid_new", CW'(M_AXIS_tvalid), CW'(1));
    checkOutput("t4_tdata_new", CW'(M_AXIS_tdata), CW'(79'h0C0C_0000_0000_0000_00C0));

    // Back-to-back pulses with tready high: sustained one pop per cycle.
    applyStimulus(79'h0D0D_0000_0000_0000_00D0, 1'b1);
    checkOutput("t5_tdata_bypass", CW'(M_AXIS_tdata), CW'(79'h0D0D_0000_0000_0000_00D0));
    checkOutput("t5_level", CW'(CQ_level), CW'(1));
    applyStimulus(79'h0D0D_0000_0000_0000_00D1, 1'b1);
    @(posedge SYS_aclk);
    #1;
    checkOutput("t5_tvalid_drained", CW'(M_AXIS_tvalid), CW'(0));
    checkOutput("t5_outstanding", CW'(CQ_outstanding), CW'(STS_ON ? 3 : 0));

    // Status returns: good (tag ignored), SLVERR, good, then one spurious.
    applyStatus(8'h83);
    checkOutput("sts1_outstanding", CW'(CQ_outstanding), CW'(STS_ON ? 2 : 0));
    checkOutput("sts1_errors", CW'(CQ_error_count), CW'(0));
    applyStatus(8'hC0);
    checkOutput("sts2_outstanding", CW'(CQ_outstanding), CW'(STS_ON ? 1 : 0));
    checkOutput("sts2_errors", CW'(CQ_error_count), CW'(STS_ON ? 1 : 0));
    applyStatus(8'h80);
    checkOutput("sts3_outstanding", CW'(CQ_outstanding), CW'(0));
    checkOutput("sts3_errors", CW'(CQ_error_count), CW'(STS_ON ? 1 : 0));
    applyStatus(8'h80);
    checkOutput("sts4_outstanding", CW'(CQ_outstanding), CW'(0));
    checkOutput("sts4_errors", CW'(CQ_error_count), CW'(STS_ON ? 2 : 0));

    checkOutput("scoreboard_empty", CW'(exp_q.size()), CW'(0));
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
